issue_ctrl: RTL
===============

# issue_ctrl

Issue and hazard controller that sits between the decode stage and the execute stage of the RV64 in-order pipeline. It keeps a per-register scoreboard of in-flight writes and stalls decode on read-after-write and write-after-write hits, since there is no bypass network. It kills wrong-path instructions after an execute-stage redirect and drains the pipeline for fence/fence.i/system instructions. It also keeps a stall-cycle performance counter.

## Interface
- `NREG`, default 32: architectural register count; scoreboard width.
- `CNT_W`, default 32: stall counter width.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `id_valid` in 1: decode holds a valid instruction.
- `rs1_r_ena`, `rs2_r_ena` in 1 each: source reads enabled.
- `rs1_r_addr`, `rs2_r_addr` in 5 each: source indices.
- `rd_w_ena` in 1: instruction writes rd.
- `rd_w_addr` in 5: destination index.
- `id_serial` in 1: fence, fence.i or system opcode; requires an empty pipeline before issue.
- `ex_redirect` in 1: execute resolved a taken branch/jump; one-cycle pulse.
- `wb_valid` in 1: writeback commits this cycle.
- `wb_rd_addr` in 5: register being committed.
- `id_ready` out 1: decode instruction accepted this cycle (combinational).
- `ex_valid` out 1: registered valid into execute.
- `flush_if` out 1: kill the fetch/decode register this cycle.
- `busy_mask` out NREG: current scoreboard.
- `stall_cnt` out CNT_W: cycles with `id_valid` high and `id_ready` low.

## Operation
- Scoreboard `sb[NREG-1:0]`:
  - Bit r set means a write to r is in flight.
  - Bit 0 is never set.
- Hazard term `haz`:
  - Set when `(rs1_r_ena & sb_eff[rs1])`, `(rs2_r_ena & sb_eff[rs2])` or `(rd_w_ena & sb_eff[rd])` (WAW).
  - `sb_eff = sb & ~wb_clr`, where `wb_clr` is the one-hot of `wb_rd_addr` when `wb_valid` is high. The register file is write-first, so a same-cycle commit satisfies the hazard.
- Issue: `id_ready = id_valid & (state==RUN) & ~haz & ~ex_redirect & ~(id_serial & (sb!=0))`.
- Scoreboard update on each edge: `sb <= (sb & ~wb_clr) | set`.
  - `set` is the one-hot of `rd_w_addr` when `id_ready & rd_w_ena & rd_w_addr!=0`.
  - Set wins over clear for the same index in the same cycle.
- `ex_valid <= id_ready` on each edge. It is forced to 0 when `ex_redirect` is high.
- FSM:
  - RUN:
    - `ex_redirect` goes to KILL.
    - `id_ready & id_serial` goes to DRAIN.
  - KILL, 1 cycle:
    - `flush_if=1`, no issue.
    - Next state RUN.
  - DRAIN:
    - No issue.
    - Returns to RUN when `sb==0` and `ex_valid==0`.
    - `ex_redirect` in DRAIN goes to KILL; the redirect has priority.
  - `flush_if` is also asserted combinationally in the same cycle as `ex_redirect`, in any state.
- `stall_cnt` increments when `id_valid & ~id_ready & state!=KILL`. It saturates at all-ones.
- A `wb_valid` commit to an index whose bit is already clear is legal and has no effect.

## Timing
- Reset (async, `rst_n` low) forces:
  - state=RUN, `sb=0`, `ex_valid=0`, `stall_cnt=0`.
  - The combinational outputs then read `flush_if=0` and `busy_mask=0`.
  - `id_ready` follows its inputs with RUN and `sb=0`.
- `rst_n` assertion mid-DRAIN or mid-KILL aborts immediately; there is no pending state after release.
- Issue decision is combinational, with 0-cycle latency from decode inputs.
- A scoreboard bit becomes visible one cycle after issue. The same-cycle dependent case cannot occur because only one instruction issues per cycle.
- Minimum redirect penalty: redirect cycle plus one KILL cycle, so issue resumes two cycles after `ex_redirect`.

## Test plan
- Reset:
  - Stimulus: release `rst_n` with `id_valid=1`, `add x5,x1,x2`.
  - Response: `id_ready=1` in the first cycle; `busy_mask=0x20` on the next edge; `ex_valid=1`.
- RAW stall:
  - Stimulus: issue `ld x5`, then `addi x6,x5,1`.
  - Response: `id_ready=0` and `stall_cnt` counts each cycle until `wb_valid` with `wb_rd_addr=5`. The addi issues in that same commit cycle; `busy_mask` goes from 0x20 to 0x40.
- x0 destination:
  - Stimulus: issue `addi x0,x0,1` twice back-to-back.
  - Response: both issue, `busy_mask` stays 0.
- Redirect:
  - Stimulus: `ex_redirect` pulse while `id_valid=1`.
  - Response: `flush_if=1` for 2 cycles (redirect cycle and KILL), `ex_valid=0` in the cycle after redirect, issue resumes in cycle +2.
- Serialize:
  - Stimulus: fence.i with `x7` pending.
  - Response: blocked until the `x7` commit. After issue, DRAIN holds `id_ready=0` until `sb==0` and `ex_valid==0`, then RUN.
- Set/clear collision:
  - Stimulus: `wb_valid` with `wb_rd_addr=9` in the same cycle as issue of a writer of x9 with `sb[9]=1`.
  - Response: WAW is cleared by the same-cycle commit, so the writer issues. `sb[9]` remains 1 after the edge.

Source files
------------

// File: rtl/issue_ctrl_if.sv
// Decode/execute/writeback handshake bundle for the issue and hazard controller.
// The master modport drives decode/execute/writeback inputs; the slave is the controller.
interface issue_ctrl_if #(
    parameter int NREG  = 32,
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic             rs1_r_ena;
    logic             rs2_r_ena;
    logic [4:0]       rs1_r_addr;
    logic [4:0]       rs2_r_addr;
    logic             rd_w_ena;
    logic [4:0]       rd_w_addr;
    logic             id_serial;
    logic             ex_redirect;
    logic             wb_valid;
    logic [4:0]       wb_rd_addr;
    logic             id_ready;
    logic             ex_valid;
    logic             flush_if;
    logic [NREG-1:0]  busy_mask;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, rs1_r_ena, rs2_r_ena, rs1_r_addr, rs2_r_addr,
               rd_w_ena, rd_w_addr, id_serial, ex_redirect, wb_valid, wb_rd_addr,
        input  id_ready, ex_valid, flush_if, busy_mask, stall_cnt
    );

    modport slave (
        input  id_valid, rs1_r_ena, rs2_r_ena, rs1_r_addr, rs2_r_addr,
               rd_w_ena, rd_w_addr, id_serial, ex_redirect, wb_valid, wb_rd_addr,
        output id_ready, ex_valid, flush_if, busy_mask, stall_cnt
    );
endinterface

// File: rtl/issue_ctrl.sv
// In-order issue controller: register scoreboard with RAW/WAW stalls, redirect kill,
// serializing-instruction drain, and a saturating stall-cycle counter.
module issue_ctrl #(
    parameter int NREG  = 32,
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    issue_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        KILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [NREG-1:0]  sb;
    logic [NREG-1:0]  sb_eff;
    logic [NREG-1:0]  wb_clr;
    logic [NREG-1:0]  set_mask;
    logic             haz;
    logic             ready;
    logic             ex_valid_q;
    logic [CNT_W-1:0] cnt;
    logic             cnt_inc;

    // Register file is write-first, so a commit in this cycle already satisfies readers.
    always_comb begin
        wb_clr = '0;
        if (bus.wb_valid) begin
            wb_clr[bus.wb_rd_addr] = 1'b1;
        end
        sb_eff = sb & ~wb_clr;
    end

    always_comb begin
        haz = (bus.rs1_r_ena & sb_eff[bus.rs1_r_addr]) |
              (bus.rs2_r_ena & sb_eff[bus.rs2_r_addr]) |
              (bus.rd_w_ena  & sb_eff[bus.rd_w_addr]);
    end

    always_comb begin
        ready = bus.id_valid & (state == RUN) & ~haz & ~bus.ex_redirect &
                ~(bus.id_serial & (sb != '0));
    end

    always_comb begin
        set_mask = '0;
        if (ready && bus.rd_w_ena && (bus.rd_w_addr != 5'd0)) begin
            set_mask[bus.rd_w_addr] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (bus.ex_redirect) begin
                    state_nxt = KILL;
                end else if (ready && bus.id_serial) begin
                    state_nxt = DRAIN;
                end
            end
            KILL: begin
                state_nxt = RUN;
            end
            DRAIN: begin
                if (bus.ex_redirect) begin
                    state_nxt = KILL;
                end else if ((sb == '0) && !ex_valid_q) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_comb begin
        cnt_inc = bus.id_valid & ~ready & (state != KILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            sb         <= '0;
            ex_valid_q <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            sb         <= sb_eff | set_mask;
            ex_valid_q <= ready & ~bus.ex_redirect;
            if (cnt_inc && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.id_ready  = ready;
    assign bus.ex_valid  = ex_valid_q;
    assign bus.flush_if  = (state == KILL) | bus.ex_redirect;
    assign bus.busy_mask = sb;
    assign bus.stall_cnt = cnt;

endmodule
